// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns pc and ir, fetches over a req/ack handshake,
// steps FETCH/DECODE/EXECUTE/WRITEBACK and resolves JMP, BEQ and HALT.
module cpu_sequencer #(
    parameter int unsigned PC_W    = 19,
    parameter int unsigned TIMEOUT = 15,
    parameter logic [4:0]  OP_BEQ  = 5'h10,
    parameter logic [4:0]  OP_JMP  = 5'h11,
    parameter logic [4:0]  OP_HALT = 5'h1F
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_rdata,
    output logic [PC_W-1:0] ir,
    output logic [PC_W-1:0] pc,
    input  logic            dec_reg_write,
    input  logic            alu_zero,
    output logic            rf_we,
    output logic [2:0]      state,
    output logic            halted,
    output logic            fault,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StWriteback = 3'd4,
        StHalt      = 3'd5,
        StFault     = 3'd6
    } state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ir_q, ir_d;
    logic [15:0]     retired_q, retired_d;
    logic [7:0]      wait_q, wait_d;
    logic            zero_q, zero_d;

    logic [4:0]      opcode;
    logic            is_ctrl;
    logic [PC_W-1:0] br_off;

    assign opcode  = ir_q[PC_W-1 -: 5];
    assign is_ctrl = (opcode == OP_BEQ) || (opcode == OP_JMP) || (opcode == OP_HALT);
    assign br_off  = {{(PC_W-8){ir_q[7]}}, ir_q[7:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
            wait_q    <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
            zero_q    <= zero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        wait_d    = wait_q;
        zero_d    = zero_q;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                    wait_d  = '0;
                end
            end
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_d == TimeoutCnt) begin
                        state_d = StFault;
                    end
                end
            end
            StDecode:  state_d = StExecute;
            StExecute: begin
                zero_d  = alu_zero;
                state_d = StWriteback;
            end
            StWriteback: begin
                if (opcode == OP_JMP) begin
                    pc_d = {{5{1'b0}}, ir_q[PC_W-6:0]};
                end else if (opcode == OP_BEQ && zero_q) begin
                    pc_d = pc_q + PC_W'(1) + br_off;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
                if (retired_q != 16'hFFFF) begin
                    retired_d = retired_q + 16'd1;
                end
                // HALT wins over run so a halting instruction never refetches
                if (opcode == OP_HALT) begin
                    state_d = StHalt;
                end else if (!run) begin
                    state_d = StIdle;
                end else begin
                    state_d = StFetch;
                    wait_d  = '0;
                end
            end
            StHalt:  state_d = StHalt;
            StFault: state_d = StFault;
            default: state_d = StFault;
        endcase
    end

    // Decoded from the state register so reset drops them without waiting for a clock
    assign imem_req  = (state_q == StFetch);
    assign imem_addr = pc_q;
    assign rf_we     = (state_q == StWriteback) && dec_reg_write && !is_ctrl;
    assign halted    = (state_q == StHalt);
    assign fault     = (state_q == StFault);
    assign state     = state_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign retired   = retired_q;

endmodule
